gpio_bank: RTL and testbench



---
 rtl/gpio_pkg.sv | 28 ++
 rtl/gpio_bank_if.sv | 15 +
 rtl/gpio_port.sv | 77 +++++++
 rtl/gpio_bank.sv | 73 +++++++
 tb/tb_gpio_bank.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO bank: register offsets within a port
// and the enum used to decode addr[2:0].
package gpio_pkg;

  localparam logic [2:0] GPIO_OUT     = 3'd0;
  localparam logic [2:0] GPIO_DIR     = 3'd1;
  localparam logic [2:0] GPIO_IN      = 3'd2;
  localparam logic [2:0] GPIO_RISE_EN = 3'd3;
  localparam logic [2:0] GPIO_FALL_EN = 3'd4;
  localparam logic [2:0] GPIO_PEND    = 3'd5;
  localparam logic [2:0] GPIO_SET     = 3'd6;
  localparam logic [2:0] GPIO_CLR     = 3'd7;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    REG_OUT     = GPIO_OUT,
    REG_DIR     = GPIO_DIR,
    REG_IN      = GPIO_IN,
    REG_RISE_EN = GPIO_RISE_EN,
    REG_FALL_EN = GPIO_FALL_EN,
    REG_PEND    = GPIO_PEND,
    REG_SET     = GPIO_SET,
    REG_CLR     = GPIO_CLR
  } gpio_reg_t;

endpackage

// File: rtl/gpio_bank_if.sv
// FemtoRV32 IO-bus slot as seen by one device: select, address, byte-masked
// write, read strobe and registered read data.
interface gpio_bank_if;
  import gpio_pkg::*;

  logic              sel;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        wmask;
  logic [DATA_W-1:0] wdata;
  logic              rstrb;
  logic [DATA_W-1:0] rdata;

  modport master (output sel, addr, wmask, wdata, rstrb, input rdata);
  modport slave  (input sel, addr, wmask, wdata, rstrb, output rdata);
endinterface

// File: rtl/gpio_port.sv
// One GPIO port: output latch, direction, edge enables, pending bits,
// input synchroniser and the combinational register read mux.
module gpio_port
  import gpio_pkg::*;
#(
  parameter int unsigned PORT_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  gpio_reg_t             reg_sel,
  input  logic [PORT_WIDTH-1:0] wr_data,
  input  logic [PORT_WIDTH-1:0] wr_mask,
  input  logic [PORT_WIDTH-1:0] pins_in,
  output logic [PORT_WIDTH-1:0] out_reg,
  output logic [PORT_WIDTH-1:0] dir_reg,
  output logic [PORT_WIDTH-1:0] rd_data,
  output logic                  pend_any
);

  logic [SYNC_STAGES-1:0][PORT_WIDTH-1:0] sync;
  logic [PORT_WIDTH-1:0] s, s_prev;
  logic [PORT_WIDTH-1:0] rise_en, fall_en, pend;
  logic [PORT_WIDTH-1:0] edges, clr;

  assign s        = sync[SYNC_STAGES-1];
  assign pend_any = |pend;

  // wr_data arrives already lane-masked, so W1C uses it directly.
  always_comb begin
    edges = ((s & ~s_prev & rise_en) | (~s & s_prev & fall_en)) & ~dir_reg;
    clr   = (wr_en && reg_sel == REG_PEND) ? wr_data : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync    <= '0;
      s_prev  <= '0;
      out_reg <= '0;
      dir_reg <= '0;
      rise_en <= '0;
      fall_en <= '0;
      pend    <= '0;
    end else begin
      sync[0] <= pins_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
      s_prev <= s;
      pend   <= (pend & ~clr) | edges;
      if (wr_en) begin
        case (reg_sel)
          REG_OUT:     out_reg <= (out_reg & ~wr_mask) | wr_data;
          REG_DIR:     dir_reg <= (dir_reg & ~wr_mask) | wr_data;
          REG_RISE_EN: rise_en <= (rise_en & ~wr_mask) | wr_data;
          REG_FALL_EN: fall_en <= (fall_en & ~wr_mask) | wr_data;
          REG_SET:     out_reg <= out_reg | wr_data;
          REG_CLR:     out_reg <= out_reg & ~wr_data;
          default:     ;
        endcase
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_OUT:     rd_data = out_reg;
      REG_DIR:     rd_data = dir_reg;
      REG_IN:      rd_data = s;
      REG_RISE_EN: rd_data = rise_en;
      REG_FALL_EN: rd_data = fall_en;
      REG_PEND:    rd_data = pend;
      default:     rd_data = '0;
    endcase
  end

endmodule

// File: rtl/gpio_bank.sv
// Multi-port GPIO peripheral on the FemtoRV32 IO bus: port decode, read
// mux with registered rdata, and a registered OR of all pending bits.
module gpio_bank
  import gpio_pkg::*;
#(
  parameter int unsigned NUM_PORTS   = 2,
  parameter int unsigned PORT_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  gpio_bank_if.slave                      bus,
  input  logic [NUM_PORTS*PORT_WIDTH-1:0] pins_in,
  output logic [NUM_PORTS*PORT_WIDTH-1:0] pins_out,
  output logic [NUM_PORTS*PORT_WIDTH-1:0] pins_oe,
  output logic                            irq
);

  logic [4:0]                            port_idx;
  gpio_reg_t                             reg_sel;
  logic                                  wr;
  logic [PORT_WIDTH-1:0]                 lane_mask, wr_bits;
  logic [NUM_PORTS-1:0][PORT_WIDTH-1:0]  port_rd;
  logic [NUM_PORTS-1:0]                  pend_any;
  logic [DATA_W-1:0]                     rd_word;

  assign port_idx = bus.addr[7:3];
  assign reg_sel  = gpio_reg_t'(bus.addr[2:0]);
  assign wr       = bus.sel & (|bus.wmask);

  always_comb begin
    lane_mask = '0;
    for (int unsigned i = 0; i < PORT_WIDTH; i++) lane_mask[i] = bus.wmask[i/8];
    wr_bits = bus.wdata[PORT_WIDTH-1:0] & lane_mask;
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    gpio_port #(
      .PORT_WIDTH (PORT_WIDTH),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_port (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr && (port_idx == 5'(p))),
      .reg_sel (reg_sel),
      .wr_data (wr_bits),
      .wr_mask (lane_mask),
      .pins_in (pins_in[p*PORT_WIDTH +: PORT_WIDTH]),
      .out_reg (pins_out[p*PORT_WIDTH +: PORT_WIDTH]),
      .dir_reg (pins_oe[p*PORT_WIDTH +: PORT_WIDTH]),
      .rd_data (port_rd[p]),
      .pend_any(pend_any[p])
    );
  end

  // Unmatched port indices (>= NUM_PORTS) fall through to zero.
  always_comb begin
    rd_word = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++)
      if (port_idx == 5'(p)) rd_word = DATA_W'(port_rd[p]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rdata <= '0;
      irq       <= 1'b0;
    end else begin
      if (bus.sel && bus.rstrb) bus.rdata <= rd_word;
      irq <= |pend_any;
    end
  end

endmodule

// File: tb/tb_gpio_bank.sv
// Scoreboard bench for gpio_bank: a cycle-level reference model built from
// pin history, directed scenarios followed by randomized bus/pin traffic.
module tb_gpio_bank;
  import gpio_pkg::*;

  localparam int unsigned NP = 2;
  localparam int unsigned PW = 8;
  localparam int unsigned SS = 2;
  localparam int unsigned NB = NP * PW;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] pins_in, pins_out, pins_oe;
  logic          irq;

  gpio_bank_if bus();

  gpio_bank #(.NUM_PORTS(NP), .PORT_WIDTH(PW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .pins_in(pins_in), .pins_out(pins_out), .pins_oe(pins_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [PW-1:0] m_out [NP];
  logic [PW-1:0] m_dir [NP];
  logic [PW-1:0] m_re  [NP];
  logic [PW-1:0] m_fe  [NP];
  logic [PW-1:0] m_pend[NP];
  logic [NB-1:0] m_s, m_sprev;
  logic          m_irq;
  logic [NB-1:0] pin_log[$];
  logic [31:0]   m_lane, m_wd;
  logic          m_wr;
  logic [PW-1:0] mv_s, mv_sp, mv_ev;

  function automatic logic [31:0] model_read(input logic [7:0] a);
    int unsigned   p = a[7:3];
    logic [PW-1:0] v = '0;
    if (p >= NP) return '0;
    case (a[2:0])
      3'd0: v = m_out[p];
      3'd1: v = m_dir[p];
      3'd2: v = m_s[p*PW +: PW];
      3'd3: v = m_re[p];
      3'd4: v = m_fe[p];
      3'd5: v = m_pend[p];
      default: v = '0;
    endcase
    return 32'(v);
  endfunction

  function automatic logic [NB-1:0] model_pack(input bit want_dir);
    logic [NB-1:0] r = '0;
    for (int p = 0; p < NP; p++) r[p*PW +: PW] = want_dir ? m_dir[p] : m_out[p];
    return r;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < NP; p++) begin
        m_out[p] = '0; m_dir[p] = '0; m_re[p] = '0; m_fe[p] = '0; m_pend[p] = '0;
      end
      m_s = '0; m_sprev = '0; m_irq = 1'b0;
      pin_log.delete();
    end else begin
      m_irq = 1'b0;
      for (int p = 0; p < NP; p++) if (m_pend[p] != 0) m_irq = 1'b1;
      for (int i = 0; i < 32; i++) m_lane[i] = bus.wmask[i/8];
      m_wd = bus.wdata & m_lane;
      m_wr = bus.sel && (bus.wmask != 0) && (bus.addr[7:3] < NP);
      for (int p = 0; p < NP; p++) begin
        mv_s  = m_s[p*PW +: PW];
        mv_sp = m_sprev[p*PW +: PW];
        mv_ev = ((mv_s & ~mv_sp & m_re[p]) | (~mv_s & mv_sp & m_fe[p])) & ~m_dir[p];
        if (m_wr && bus.addr[7:3] == p) begin
          case (bus.addr[2:0])
            3'd0: m_out[p]  = (m_out[p] & ~m_lane[PW-1:0]) | m_wd[PW-1:0];
            3'd1: m_dir[p]  = (m_dir[p] & ~m_lane[PW-1:0]) | m_wd[PW-1:0];
            3'd3: m_re[p]   = (m_re[p]  & ~m_lane[PW-1:0]) | m_wd[PW-1:0];
            3'd4: m_fe[p]   = (m_fe[p]  & ~m_lane[PW-1:0]) | m_wd[PW-1:0];
            3'd5: m_pend[p] = m_pend[p] & ~m_wd[PW-1:0];
            3'd6: m_out[p]  = m_out[p] | m_wd[PW-1:0];
            3'd7: m_out[p]  = m_out[p] & ~m_wd[PW-1:0];
            default: ;
          endcase
        end
        m_pend[p] = m_pend[p] | mv_ev;
      end
      pin_log.push_back(pins_in);
      m_sprev = m_s;
      m_s = (pin_log.size() >= SS) ? pin_log[pin_log.size() - SS] : '0;
    end
  end

  // ---------------- scoreboard / monitors ----------------
  typedef struct { logic [31:0] value; logic [7:0] addr; } rd_t;
  rd_t         sb[$];
  rd_t         e;
  logic        rd_fire;
  logic [31:0] last_rd;

  always @(posedge clk) begin
    if (reset) begin
      rd_fire = 1'b0;
      last_rd = '0;
    end else begin
      rd_fire = bus.sel && bus.rstrb;
    end
    @(negedge clk);
    if (rd_fire) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL rdata_unexpected: got %h expected no read", bus.rdata);
      end else begin
        e = sb.pop_front();
        chk($sformatf("rdata_addr_%02h", e.addr), bus.rdata, e.value);
        last_rd = e.value;
      end
    end else begin
      chk("rdata_hold", bus.rdata, last_rd);
    end
  end

  always @(negedge clk) begin
    chk("pins_out", 32'(pins_out), 32'(model_pack(1'b0)));
    chk("pins_oe",  32'(pins_oe),  32'(model_pack(1'b1)));
    chk("irq",      32'(irq),      32'(m_irq));
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    bus.sel = 1'b0; bus.rstrb = 1'b0; bus.wmask = '0;
    repeat (n) @(negedge clk);
  endtask

  task automatic op(input bit w, input bit r, input logic [4:0] port, input logic [2:0] rg,
                    input logic [31:0] d, input logic [3:0] m);
    bus.sel   = w | r;
    bus.rstrb = r;
    bus.wmask = w ? m : 4'h0;
    bus.addr  = {port, rg};
    bus.wdata = d;
    if (r) sb.push_back('{value: model_read({port, rg}), addr: {port, rg}});
    @(negedge clk);
    bus.sel = 1'b0; bus.rstrb = 1'b0; bus.wmask = '0;
  endtask

  task automatic wr(input logic [4:0] port, input logic [2:0] rg, input logic [31:0] d);
    op(1'b1, 1'b0, port, rg, d, 4'hF);
  endtask

  task automatic rd(input logic [4:0] port, input logic [2:0] rg);
    op(1'b0, 1'b1, port, rg, '0, 4'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned kind;
    logic [4:0]  port;
    bus.sel = 1'b0; bus.rstrb = 1'b0; bus.wmask = '0; bus.addr = '0; bus.wdata = '0;
    reset   = 1'b1;
    pins_in = NB'($urandom);
    repeat (3) @(negedge clk);
    chk("reset_rdata", bus.rdata, 32'h0);
    chk("reset_pins_out", 32'(pins_out), 32'h0);
    chk("reset_pins_oe", 32'(pins_oe), 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    reset = 1'b0;
    idle(3);
    for (int r = 0; r < 8; r++) begin
      rd(5'd0, 3'(r));
      if (r == 2) chk("reset_in_eq_pins", bus.rdata, 32'(pins_in[7:0]));
      else        chk("reset_reg_zero", bus.rdata, 32'h0);
    end

    // output path on port 1
    wr(5'd1, GPIO_DIR, 32'hFF);
    wr(5'd1, GPIO_OUT, 32'hA5);  chk("out_a5", 32'(pins_out[15:8]), 32'hA5);
    wr(5'd1, GPIO_SET, 32'h0F);  chk("set_af", 32'(pins_out[15:8]), 32'hAF);
    wr(5'd1, GPIO_CLR, 32'h80);  chk("clr_2f", 32'(pins_out[15:8]), 32'h2F);
    rd(5'd1, GPIO_OUT);          chk("read_out_2f", bus.rdata, 32'h2F);
    chk("oe_ff", 32'(pins_oe[15:8]), 32'hFF);

    // input synchroniser latency
    pins_in = '0;
    idle(4);
    pins_in[3] = 1'b1;
    rd(5'd0, GPIO_IN); chk("sync_in_e0", bus.rdata, 32'h00);
    rd(5'd0, GPIO_IN); chk("sync_in_e1", bus.rdata, 32'h00);
    rd(5'd0, GPIO_IN); chk("sync_in_e2", bus.rdata, 32'h08);

    // rising edge interrupt and W1C
    pins_in = '0;
    idle(4);
    wr(5'd0, GPIO_RISE_EN, 32'h01);
    pins_in[0] = 1'b1;
    idle(2);
    rd(5'd0, GPIO_PEND); chk("pend_before", bus.rdata, 32'h00);
    rd(5'd0, GPIO_PEND); chk("pend_rise", bus.rdata, 32'h01);
    chk("irq_rise", 32'(irq), 32'h1);
    wr(5'd0, GPIO_PEND, 32'h01);
    idle(1);
    chk("irq_w1c", 32'(irq), 32'h0);
    pins_in[0] = 1'b0;
    idle(4);
    rd(5'd0, GPIO_PEND); chk("fall_disabled", bus.rdata, 32'h00);
    chk("irq_fall_disabled", 32'(irq), 32'h0);

    // output pins ignore edges
    wr(5'd0, GPIO_DIR, 32'h04);
    wr(5'd0, GPIO_RISE_EN, 32'h04);
    wr(5'd0, GPIO_FALL_EN, 32'h04);
    pins_in[2] = 1'b1; idle(4);
    pins_in[2] = 1'b0; idle(4);
    rd(5'd0, GPIO_PEND); chk("dir_masks_edge", bus.rdata, 32'h00);
    wr(5'd0, GPIO_DIR, 32'h00);

    // falling edge colliding with W1C of the same bit
    wr(5'd0, GPIO_RISE_EN, 32'h00);
    wr(5'd0, GPIO_FALL_EN, 32'h02);
    pins_in[1] = 1'b1; idle(4);
    pins_in[1] = 1'b0; idle(4);
    chk("irq_fall", 32'(irq), 32'h1);
    pins_in[1] = 1'b1; idle(4);
    pins_in[1] = 1'b0; idle(2);
    wr(5'd0, GPIO_PEND, 32'h02);
    chk("irq_collision", 32'(irq), 32'h1);
    rd(5'd0, GPIO_PEND); chk("pend_collision", bus.rdata, 32'h02);
    chk("irq_collision_hold", 32'(irq), 32'h1);

    // out-of-range port
    wr(5'd5, GPIO_OUT, 32'hFF);
    rd(5'd5, GPIO_OUT); chk("oor_read", bus.rdata, 32'h0);
    chk("oor_no_write", 32'(pins_out), 32'h2F00);

    // reset in the middle of activity overrides a write
    wr(5'd0, GPIO_OUT, 32'hFF);
    chk("out_ff", 32'(pins_out[7:0]), 32'hFF);
    reset = 1'b1;
    op(1'b1, 1'b0, 5'd1, GPIO_OUT, 32'h55, 4'hF);
    reset = 1'b0;
    chk("midreset_out", 32'(pins_out), 32'h0);
    chk("midreset_oe", 32'(pins_oe), 32'h0);
    chk("midreset_irq", 32'(irq), 32'h0);
    chk("midreset_rdata", bus.rdata, 32'h0);

    // randomized traffic
    pins_in = NB'($urandom);
    for (int it = 0; it < 800; it++) begin
      if ($urandom_range(2) == 0) pins_in = pins_in ^ NB'(32'h1 << $urandom_range(NB-1));
      kind = $urandom_range(3);
      port = ($urandom_range(7) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(NP-1));
      case (kind)
        0: idle(1);
        1: op(1'b1, 1'b0, port, 3'($urandom_range(7)), $urandom,
              $urandom_range(1) ? 4'hF : 4'($urandom));
        2: op(1'b0, 1'b1, port, 3'($urandom_range(7)), '0, 4'h0);
        default: op(1'b1, 1'b1, port, 3'($urandom_range(7)), $urandom, 4'($urandom));
      endcase
    end

    idle(3);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
